// File: rtl/universal_shift_reg.sv
// Universal shift register: load, shift, rotate and arithmetic shift,
// running multi-step commands from a START strobe. State changes on the falling clock edge.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    input  logic [2:0]       MODE,
    input  logic [CW-1:0]    COUNT,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    state_t             state, state_nxt;
    logic [CW-1:0]      rem, rem_nxt;
    logic [2:0]         mode_r, mode_nxt;
    logic [WIDTH-1:0]   q, q_nxt;
    logic               sout, sout_nxt;
    logic               done, done_nxt;

    logic [2:0]         step_mode;
    logic               left_dir;
    logic               lsb_fill, msb_fill;
    logic [WIDTH-1:0]   q_step;
    logic               sout_step;
    logic               start_shift;

    // The start edge uses the live MODE; later edges use the latched copy.
    assign step_mode = (state == RUN) ? mode_r : MODE;

    always_comb begin
        left_dir = (step_mode == M_SHL) || (step_mode == M_ROL);
        lsb_fill = (step_mode == M_ROL) ? q[WIDTH-1] : SIL;
        case (step_mode)
            M_SHR:   msb_fill = SIR;
            M_ROR:   msb_fill = q[0];
            M_ASR:   msb_fill = q[WIDTH-1];
            default: msb_fill = 1'b0;
        endcase
        if (left_dir) begin
            q_step    = {q[WIDTH-2:0], lsb_fill};
            sout_step = q[WIDTH-1];
        end else begin
            q_step    = {msb_fill, q[WIDTH-1:1]};
            sout_step = q[0];
        end
    end

    assign start_shift = (MODE == M_SHL) || (MODE == M_SHR) || (MODE == M_ROL) ||
                         (MODE == M_ROR) || (MODE == M_ASR);

    // State register
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            rem    <= '0;
            mode_r <= M_HOLD;
            q      <= '0;
            sout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            mode_r <= mode_nxt;
            q      <= q_nxt;
            sout   <= sout_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        mode_nxt  = mode_r;
        q_nxt     = q;
        sout_nxt  = sout;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    mode_nxt = MODE;
                    done_nxt = 1'b1;
                    if (MODE == M_LOAD) begin
                        q_nxt = D;
                    end else if (start_shift && (COUNT != '0)) begin
                        q_nxt    = q_step;
                        sout_nxt = sout_step;
                        if (COUNT != CW'(1)) begin
                            done_nxt  = 1'b0;
                            state_nxt = RUN;
                            rem_nxt   = COUNT - CW'(1);
                        end
                    end
                end
            end
            RUN: begin
                q_nxt    = q_step;
                sout_nxt = sout_step;
                rem_nxt  = rem - CW'(1);
                if (rem == CW'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        Q    = q;
        SOUT = sout;
        DONE = done;
        BUSY = (state == RUN);
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8); inputs change and outputs
// are sampled 1 time unit after each falling edge.
module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          CLK = 1'b1;
    logic          RST;
    logic [W-1:0]  D;
    logic          SIL, SIR;
    logic [2:0]    MODE;
    logic [CW-1:0] COUNT;
    logic          START;
    logic [W-1:0]  Q;
    logic          SOUT, BUSY, DONE;

    int n_cmp = 0;
    int n_bad = 0;

    universal_shift_reg #(.WIDTH(W), .CW(CW)) dut (
        .CLK(CLK), .RST(RST), .D(D), .SIL(SIL), .SIR(SIR), .MODE(MODE),
        .COUNT(COUNT), .START(START), .Q(Q), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic cmd(input logic [2:0] m, input int cnt, input logic [W-1:0] d);
        MODE  = m;
        COUNT = CW'(cnt);
        D     = d;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    initial begin
        RST = 1'b1; D = '0; SIL = 1'b0; SIR = 1'b0; MODE = 3'd0; COUNT = '0; START = 1'b0;
        #2;
        chk("rst_q", Q, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_sout", SOUT, 0);
        tick();
        RST = 1'b0;

        // LOAD 0xA5
        cmd(3'b001, 0, 8'hA5);
        chk("load_q", Q, 8'hA5);
        chk("load_done", DONE, 1);
        chk("load_busy", BUSY, 0);
        tick();
        chk("load_done_off", DONE, 0);
        chk("load_hold_q", Q, 8'hA5);

        // SHL x3, SIL=1
        SIL = 1'b1;
        cmd(3'b010, 3, 8'h00);
        chk("shl_s1_q", Q, 8'h4B);
        chk("shl_s1_busy", BUSY, 1);
        chk("shl_s1_sout", SOUT, 1);
        chk("shl_s1_done", DONE, 0);
        tick();
        chk("shl_s2_q", Q, 8'h97);
        chk("shl_s2_busy", BUSY, 1);
        chk("shl_s2_sout", SOUT, 0);
        tick();
        chk("shl_s3_q", Q, 8'h2F);
        chk("shl_s3_sout", SOUT, 1);
        chk("shl_s3_busy", BUSY, 0);
        chk("shl_s3_done", DONE, 1);
        tick();
        chk("shl_done_off", DONE, 0);

        // LOAD 0x81, then ROR x9 back-to-back on the DONE cycle
        cmd(3'b001, 0, 8'h81);
        chk("ld81_q", Q, 8'h81);
        cmd(3'b101, 9, 8'h00);
        chk("ror_s1_q", Q, 8'hC0);
        for (int i = 2; i <= 8; i++) tick();
        chk("ror_s8_busy", BUSY, 1);
        chk("ror_s8_done", DONE, 0);
        tick();
        chk("ror_q", Q, 8'hC0);
        chk("ror_sout", SOUT, 1);
        chk("ror_done", DONE, 1);
        chk("ror_busy", BUSY, 0);

        // LOAD 0x80, ASR x4 with a LOAD strobe during BUSY
        cmd(3'b001, 0, 8'h80);
        cmd(3'b110, 4, 8'h00);
        chk("asr_s1_q", Q, 8'hC0);
        cmd(3'b001, 0, 8'h55);
        chk("asr_s2_q", Q, 8'hE0);
        tick();
        chk("asr_s3_q", Q, 8'hF0);
        tick();
        chk("asr_q", Q, 8'hF8);
        chk("asr_done", DONE, 1);
        tick();
        chk("idle_hold_q", Q, 8'hF8);
        chk("idle_done", DONE, 0);

        // SHR x5 aborted by reset after the second edge
        SIR = 1'b0;
        cmd(3'b011, 5, 8'h00);
        chk("shr_s1_q", Q, 8'h7C);
        tick();
        chk("shr_s2_q", Q, 8'h3E);
        RST = 1'b1;
        #1;
        chk("abort_q", Q, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("post_rst_done", DONE, 0);
        chk("post_rst_busy", BUSY, 0);
        cmd(3'b001, 0, 8'h3C);
        chk("ld3c_q", Q, 8'h3C);

        // COUNT=0 SHL, then LOAD 0x11 on its DONE cycle
        tick();
        cmd(3'b010, 0, 8'h00);
        chk("cnt0_q", Q, 8'h3C);
        chk("cnt0_done", DONE, 1);
        chk("cnt0_busy", BUSY, 0);
        cmd(3'b001, 0, 8'h11);
        chk("b2b_q", Q, 8'h11);
        chk("b2b_done", DONE, 1);

        // SIL sampled live at each step
        SIL = 1'b1;
        cmd(3'b010, 2, 8'h00);
        chk("live_s1_q", Q, 8'h23);
        SIL = 1'b0;
        tick();
        chk("live_s2_q", Q, 8'h46);

        // single-step rotates stay IDLE and pulse DONE
        cmd(3'b100, 1, 8'h00);
        chk("rol1_q", Q, 8'h8C);
        chk("rol1_busy", BUSY, 0);
        chk("rol1_done", DONE, 1);
        cmd(3'b100, 1, 8'h00);
        chk("rol2_q", Q, 8'h19);
        chk("rol2_sout", SOUT, 1);

        // reserved mode holds Q and SOUT
        cmd(3'b111, 3, 8'hFF);
        chk("rsv_q", Q, 8'h19);
        chk("rsv_sout", SOUT, 1);
        chk("rsv_done", DONE, 1);
        chk("rsv_busy", BUSY, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        n_bad++;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
